// File: rtl/uart_rx_deframer_if.sv
// Parallel-side bundle of the UART receive deframer: baud tick, serial
// line and parity selection in, assembled frame fields and status out.
// The slave modport is taken by the deframer; the master modport by
// whatever drives the line and consumes the fields.
interface uart_rx_deframer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  baud_tick;
  logic                  data_rx;
  logic [1:0]            parity_type;
  logic [DATA_WIDTH-1:0] raw_data;
  logic                  parity_bit;
  logic                  start_bit;
  logic                  stop_bit;
  logic                  recieved_flag;
  logic                  active_flag;

  modport master (
    output baud_tick, data_rx, parity_type,
    input  raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active_flag
  );

  modport slave (
    input  baud_tick, data_rx, parity_type,
    output raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active_flag
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes the serial line, finds the start bit,
// samples every bit at its midpoint (OVERSAMPLE baud ticks per bit) and
// presents start/data/parity/stop as parallel fields with a one-clock
// recieved_flag strobe for the downstream error checker.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit becomes the 2-of-3
// majority of the ticks around its midpoint, decided one tick later.
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic               clock,
  input logic               reset_n,
  uart_rx_deframer_if.slave rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Counter value on which each state makes its bit decision. With voting
  // the START decision slips one tick past the midpoint; the counter then
  // restarts one tick late, so the later bits keep OVERSAMPLE-1 and still
  // decide one tick after their own midpoints.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [1:0]    ptype_q;
  logic          rx_meta;
  logic          rx_s;
  logic          sample_bit;

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the two stages.
      rx_meta <= rx.data_rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_hist;

  // Line values seen on the two previous baud ticks (mid-1 and mid at the
  // decision tick); the current rx_s supplies mid+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vote_hist <= 2'b11;
    end else if (rx.baud_tick) begin
      vote_hist <= {vote_hist[0], rx_s};
    end
  end

  assign sample_bit = (vote_hist[1] & vote_hist[0]) |
                      (vote_hist[1] & rx_s) |
                      (vote_hist[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // Frame FSM with registered field and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      tick_cnt         <= '0;
      bit_cnt          <= '0;
      ptype_q          <= 2'b00;
      rx.raw_data      <= '0;
      rx.start_bit     <= 1'b0;
      rx.parity_bit    <= 1'b1;
      rx.stop_bit      <= 1'b1;
      rx.recieved_flag <= 1'b0;
      rx.active_flag   <= 1'b0;
    end else begin
      rx.recieved_flag <= 1'b0;
      if (rx.baud_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state          <= START;
              tick_cnt       <= '0;
              ptype_q        <= rx.parity_type;
              rx.active_flag <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == START_LAST) begin
              tick_cnt <= '0;
              if (!sample_bit) begin
                rx.start_bit <= 1'b0;
                bit_cnt      <= '0;
                state        <= DATA;
              end else begin
                // Glitch shorter than half a bit: drop it silently.
                state          <= IDLE;
                rx.active_flag <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt             <= '0;
              rx.raw_data[bit_cnt] <= sample_bit;
              if (bit_cnt == BIT_MAX) begin
                bit_cnt <= '0;
                if (^ptype_q) begin
                  state <= PARITY;
                end else begin
                  rx.parity_bit <= 1'b1;
                  state         <= STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt      <= '0;
              rx.parity_bit <= sample_bit;
              state         <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == BIT_LAST) begin
              // A low stop bit is still reported; the checker flags it.
              tick_cnt         <= '0;
              rx.stop_bit      <= sample_bit;
              rx.recieved_flag <= 1'b1;
              rx.active_flag   <= 1'b0;
              state            <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state          <= IDLE;
            tick_cnt       <= '0;
            rx.active_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: drives whole frames one baud-tick slot
// at a time (4 clocks per slot, 16 slots per bit) and compares the received
// fields against hand-computed values. Honours UART_RX_MAJORITY_VOTE_EN.
module tb_uart_rx_deframer;

  localparam int DW = 8;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam bit VOTE = 1'b1;
`else
  localparam bit VOTE = 1'b0;
`endif
  // Last stop-bit slot that carries the requested stop value: the slot on
  // which the deframer decides; later slots idle high so no new start is seen.
  localparam int STOP_LOW_LAST = VOTE ? OS / 2 + 1 : OS / 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int flag_cnt    = 0;
  int flag_wide   = 0;
  bit prev_flag   = 1'b0;

  always #5 clock = ~clock;

  uart_rx_deframer_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_deframer #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .rx     (bus)
  );

  // Count strobes and catch any strobe longer than one clock.
  always @(negedge clock) begin
    if (bus.recieved_flag === 1'b1) begin
      flag_cnt++;
      if (prev_flag) flag_wide++;
    end
    prev_flag = (bus.recieved_flag === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One baud-tick slot: line set at a falling edge, tick on the 4th clock,
  // leaving two clocks for the synchronizer to settle before the tick.
  task automatic slot(input logic v);
    bus.data_rx = v;
    repeat (3) @(negedge clock);
    bus.baud_tick = 1'b1;
    @(negedge clock);
    bus.baud_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) slot(1'b1);
  endtask

  // glitch_bit: data bit whose midpoint slot is forced low (-1 = none).
  // abort_bit: data bit during which reset_n is pulsed (-1 = none).
  // pt_mid: parity_type value driven after the start edge.
  task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pt,
                            input logic stop_v, input int glitch_bit,
                            input int abort_bit, input logic [1:0] pt_mid);
    logic par;
    bus.parity_type = pt;
    for (int s = 0; s < OS; s++) begin
      slot(1'b0);
      if (s == 2) bus.parity_type = pt_mid;
      if (s == 12) check("active_mid", {31'd0, bus.active_flag}, 32'd1);
    end
    for (int i = 0; i < DW; i++) begin
      for (int s = 0; s < OS; s++) begin
        if (i == abort_bit && s == 4) begin
          bus.data_rx = 1'b1;
          reset_n = 1'b0;
          @(negedge clock);
          reset_n = 1'b1;
          return;
        end
        slot((i == glitch_bit && s == OS / 2) ? 1'b0 : d[i]);
      end
    end
    if (pt == 2'b01 || pt == 2'b10) begin
      par = (pt == 2'b10) ? ^d : ~^d;
      repeat (OS) slot(par);
    end
    for (int s = 0; s < OS; s++) slot((s <= STOP_LOW_LAST) ? stop_v : 1'b1);
  endtask

  task automatic check_fields(input string tag, input logic [DW-1:0] d,
                              input logic par, input logic stop_v);
    check({tag, "_raw"},    {24'd0, bus.raw_data},   {24'd0, d});
    check({tag, "_parity"}, {31'd0, bus.parity_bit}, {31'd0, par});
    check({tag, "_start"},  {31'd0, bus.start_bit},  32'd0);
    check({tag, "_stop"},   {31'd0, bus.stop_bit},   {31'd0, stop_v});
    check({tag, "_active"}, {31'd0, bus.active_flag}, 32'd0);
  endtask

  initial begin
    bus.baud_tick   = 1'b0;
    bus.data_rx     = 1'b1;
    bus.parity_type = 2'b00;
    repeat (3) @(negedge clock);

    // Reset values.
    check("rst_raw",    {24'd0, bus.raw_data},       32'd0);
    check("rst_parity", {31'd0, bus.parity_bit},     32'd1);
    check("rst_start",  {31'd0, bus.start_bit},      32'd0);
    check("rst_stop",   {31'd0, bus.stop_bit},       32'd1);
    check("rst_flag",   {31'd0, bus.recieved_flag},  32'd0);
    check("rst_active", {31'd0, bus.active_flag},    32'd0);
    reset_n = 1'b1;
    idle(8);

    // Even parity 0xA5 (parity 0); parity_type dropped to 00 mid-frame.
    send_frame(8'hA5, 2'b10, 1'b1, -1, -1, 2'b00);
    idle(4);
    check("even_flags", flag_cnt, 32'd1);
    check_fields("even", 8'hA5, 1'b0, 1'b1);

    // Odd parity 0x3C (parity 1) then 0xFF back-to-back (parity 1).
    send_frame(8'h3C, 2'b01, 1'b1, -1, -1, 2'b01);
    check("odd1_flags", flag_cnt, 32'd2);
    check_fields("odd1", 8'h3C, 1'b1, 1'b1);
    send_frame(8'hFF, 2'b01, 1'b1, -1, -1, 2'b01);
    idle(4);
    check("odd2_flags", flag_cnt, 32'd3);
    check_fields("odd2", 8'hFF, 1'b1, 1'b1);

    // No parity 0x81 with a framing error (stop sampled 0).
    send_frame(8'h81, 2'b00, 1'b0, -1, -1, 2'b00);
    idle(4);
    check("ferr_flags", flag_cnt, 32'd4);
    check_fields("ferr", 8'h81, 1'b1, 1'b0);

    // Four-slot low glitch: rejected in START, fields untouched.
    repeat (2) slot(1'b0);
    check("glitch_active", {31'd0, bus.active_flag}, 32'd1);
    repeat (2) slot(1'b0);
    idle(24);
    check("glitch_flags", flag_cnt, 32'd4);
    check_fields("glitch", 8'h81, 1'b1, 1'b0);

    // Reset during data bit 4 of 0x55, then a clean 0x12.
    send_frame(8'h55, 2'b00, 1'b1, -1, 4, 2'b00);
    check("abort_raw",    {24'd0, bus.raw_data},    32'd0);
    check("abort_parity", {31'd0, bus.parity_bit},  32'd1);
    check("abort_stop",   {31'd0, bus.stop_bit},    32'd1);
    check("abort_active", {31'd0, bus.active_flag}, 32'd0);
    idle(40);
    check("abort_flags", flag_cnt, 32'd4);
    send_frame(8'h12, 2'b00, 1'b1, -1, -1, 2'b00);
    idle(4);
    check("clean_flags", flag_cnt, 32'd5);
    check_fields("clean", 8'h12, 1'b1, 1'b1);

    // 0x07 with bit 2 forced low on its midpoint slot only.
    send_frame(8'h07, 2'b00, 1'b1, 2, -1, 2'b00);
    idle(4);
    check("vote_flags", flag_cnt, 32'd6);
    check_fields("vote", VOTE ? 8'h07 : 8'h03, 1'b1, 1'b1);

    check("flag_width", flag_wide, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side deserializer (SIPO) that sits directly upstream of the receive error checker.
- Oversamples the serial line, locates the start bit and samples each bit at its midpoint.
- Assembles start, data, optional parity and stop bits into parallel fields.
- Pulses a one-cycle frame-received strobe. The downstream checker evaluates the fields combinationally during that strobe.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, sent LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- baud_tick  input  1  one-clock pulse at OVERSAMPLE x baud rate.
- data_rx  input  1  asynchronous serial line; idles high.
- parity_type  input  2  01 = odd, 10 = even, 00 or 11 = no parity.
- raw_data  output  DATA_WIDTH  assembled data byte.
- parity_bit  output  1  sampled parity bit; forced 1 when no parity.
- start_bit  output  1  sampled start bit.
- stop_bit  output  1  sampled stop bit.
- recieved_flag  output  1  one-clock pulse; frame fields valid.
- active_flag  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE, all counters 0.
  - raw_data = 0, start_bit = 0, parity_bit = 1, stop_bit = 1, recieved_flag = 0, active_flag = 0.
- Input synchronizer:
  - data_rx passes through a 2-flop synchronizer that resets to 1.
  - All sampling uses the synchronized value rx_s.
- Counters and latches:
  - tick_cnt has width clog2(OVERSAMPLE). It advances only on baud_tick and clears on every state change.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
  - parity_type is latched on the IDLE->START transition. Changes to it mid-frame are ignored.
- IDLE:
  - On baud_tick with rx_s = 0, go to START.
- START:
  - On the baud_tick where tick_cnt = OVERSAMPLE/2-1, sample the line.
  - Sample 0: set start_bit = 0 and go to DATA.
  - Sample 1: false start, return to IDLE. Outputs unchanged, no recieved_flag.
- DATA:
  - Sample on the baud_tick where tick_cnt = OVERSAMPLE-1.
  - Shift the sample into raw_data[bit_cnt] (LSB first) and increment bit_cnt.
  - After bit DATA_WIDTH-1, go to PARITY if the latched parity type is 01 or 10; otherwise go to STOP with parity_bit = 1.
- PARITY:
  - Sample at tick_cnt = OVERSAMPLE-1 into parity_bit, then go to STOP.
- STOP:
  - Sample at tick_cnt = OVERSAMPLE-1 into stop_bit.
  - On the next clock, pulse recieved_flag for exactly one clock and return to IDLE.
  - A framing error (stop sampled 0) is still reported via recieved_flag; the checker flags it.
- Output update rules:
  - raw_data, parity_bit, start_bit and stop_bit hold their values until overwritten by the next frame.
  - They update only during sampling, never between recieved_flag and the next start.
  - The next frame's start can be detected from the clock after recieved_flag; the back-to-back frame gap is half a stop bit.
- Sample latency: the midpoint of each bit falls OVERSAMPLE/2 ticks after the detected start edge plus N*OVERSAMPLE ticks, plus 2 clocks of synchronizer delay.
- A baud_tick held high for consecutive clocks counts once per clock. Upstream guarantees single-cycle pulses.
- Reset asserted mid-frame:
  - Immediate return to IDLE with reset values.
  - No recieved_flag for the aborted frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit is the 2-of-3 majority of rx_s at ticks mid-1, mid and mid+1 (mid = OVERSAMPLE/2-1 for START, OVERSAMPLE-1 otherwise).
  - The decision is made at mid+1. State transitions are delayed accordingly; the bit period is unchanged.
  - START validation also uses the vote.
- Not defined: single sample at mid as above.

Test Plan:
- Even parity (10), frame 0, data 0xA5 LSB first, parity 0, stop 1 -> recieved_flag pulses once; raw_data = 0xA5, parity_bit = 0, start_bit = 0, stop_bit = 1.
- Odd parity (01), data 0x3C, parity 1, followed immediately by a second frame with data 0xFF -> two recieved_flag pulses; raw_data = 0x3C, then 0xFF.
- No parity (00), data 0x81, stop bit driven 0 -> recieved_flag pulses; raw_data = 0x81, parity_bit = 1, stop_bit = 0.
- 4-tick low glitch on an idle line -> START rejects it; no recieved_flag, outputs unchanged, active_flag back to 0.
- reset_n pulsed low during data bit 4 of frame 0x55, then a clean frame 0x12 -> no flag for the aborted frame; one flag with raw_data = 0x12.
- With UART_RX_MAJORITY_VOTE_EN, data bit 2 = 1 with the line forced 0 for one tick at its midpoint -> raw_data bit 2 = 1. Without the macro -> raw_data bit 2 = 0.
